adpll_gain_scheduler: RTL and testbench
=======================================

ADPLL_GAIN_SCHEDULER -- requirements
Module: adpll_gain_scheduler

Interface
REQ-001 Parameter PDET_WIDTH, default 5: width of each node's signed phase-error word.
REQ-002 Parameter KP_WIDTH, default 8: proportional gain width.
REQ-003 Parameter KI_WIDTH, default 10: integral gain width.
REQ-004 Parameter LOCK_THRESH, default 2: max |error| counted as in-window.
REQ-005 Parameter LOCK_COUNT, default 64: consecutive in-window reference edges needed to declare lock.
REQ-006 Parameter UNLOCK_COUNT, default 4: consecutive out-of-window reference edges needed to declare loss of lock.
REQ-007 Parameter SETTLE_CYCLES, default 1024: fpga_clk_i cycles between successive node enables.
REQ-008 fpga_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-009 reset_i  in  1  synchronous, active-high reset.
REQ-010 start_i  in  1  level; high runs the sequence, low forces IDLE.
REQ-011 ref_i  in  1  reference clock, asynchronous to fpga_clk_i.
REQ-012 error_i  in  4*PDET_WIDTH  two's-complement error per node; node n (0=11, 1=12, 2=21, 3=22) at bits [n*PDET_WIDTH +: PDET_WIDTH].
REQ-013 kp_acq_i / ki_acq_i  in  KP_WIDTH / KI_WIDTH  acquisition gains.
REQ-014 kp_trk_i / ki_trk_i  in  KP_WIDTH / KI_WIDTH  tracking gains.
REQ-015 node_enable_o  out  4  per-node enable, bit n = node n.
REQ-016 kp_o / ki_o  out  KP_WIDTH / KI_WIDTH  gains broadcast to all nodes, registered.
REQ-017 locked_o  out  1  high only in TRACK.
REQ-018 state_o  out  2  IDLE=0, STAGGER=1, ACQUIRE=2, TRACK=3.
REQ-019 lock_loss_cnt_o  out  8  count of TRACK->ACQUIRE transitions, saturates at 255.

Function
REQ-020 ref_i shall pass a 2-flop synchronizer then a rising-edge detector; ref_tick is a one-cycle pulse, 3 cycles after the ref_i rising edge.
REQ-021 A node is in-window when |error| <= LOCK_THRESH, magnitude computed at PDET_WIDTH+1 bits so the most negative value (-16 at width 5) yields 16, no overflow.
REQ-022 win_ok = all nodes whose node_enable_o bit is 1 are in-window; disabled nodes are ignored.
REQ-023 IDLE: node_enable_o=0, kp_o=0, ki_o=0; start_i=1 -> STAGGER.
REQ-024 STAGGER entry: node_enable_o=0001, settle counter=0; counter increments each cycle; at SETTLE_CYCLES-1 it wraps and node_enable_o shifts in the next 1 (0011, 0111, 1111); wrap with 1111 -> ACQUIRE.
REQ-025 STAGGER and ACQUIRE: kp_o=kp_acq_i, ki_o=ki_acq_i. TRACK: kp_o=kp_trk_i, ki_o=ki_trk_i. Outputs are registered from next-state, so gains change on the same edge as state_o; gain input changes propagate in 1 cycle.
REQ-026 ACQUIRE: on ref_tick with win_ok, good_cnt increments; on ref_tick without win_ok, good_cnt=0; ref_tick with win_ok and good_cnt=LOCK_COUNT-1 -> TRACK, good_cnt=0.
REQ-027 TRACK: on ref_tick without win_ok, bad_cnt increments; with win_ok, bad_cnt=0; ref_tick without win_ok and bad_cnt=UNLOCK_COUNT-1 -> ACQUIRE, bad_cnt=0, lock_loss_cnt_o+1 (saturating).
REQ-028 Counters change only on ref_tick outside STAGGER; no ref_tick means no change.
REQ-029 start_i=0 in any state -> IDLE on next edge, overriding a simultaneous ref_tick or settle wrap; good_cnt, bad_cnt, settle counter cleared; lock_loss_cnt_o retained.
REQ-030 Re-assertion of start_i from IDLE restarts STAGGER from 0001.

Reset
REQ-031 reset_i=1 at a clock edge: state IDLE, node_enable_o=0, kp_o=0, ki_o=0, locked_o=0, lock_loss_cnt_o=0, all internal counters and synchronizer flops 0; reset overrides start_i.
REQ-032 Reset asserted mid-sequence (any state) shall take effect on that edge with identical values to REQ-031.

Verification (bench params: SETTLE_CYCLES=8, LOCK_COUNT=4, UNLOCK_COUNT=2, LOCK_THRESH=2)
REQ-033 Stagger: reset, start_i=1 -> node_enable_o 0001, 0011, 0111, 1111 at 8-cycle intervals, state_o=2 after 32 cycles in STAGGER, kp_o=kp_acq_i throughout.
REQ-034 Lock: errors all +1/-2, 4 ref edges -> state_o=3, locked_o=1, kp_o=kp_trk_i, ki_o=ki_trk_i on the edge after the 4th ref_tick.
REQ-035 Window reset: 3 good edges, 1 edge with node 3 error=+3, then 4 good edges -> lock only after the 8th edge.
REQ-036 Unlock: in TRACK, node 0 error=-16 for 2 ref edges -> state_o=2, lock_loss_cnt_o=1, acquisition gains; 1 bad then 1 good edge -> stays TRACK.
REQ-037 Abort: start_i=0 during TRACK coincident with ref_tick -> IDLE next edge, outputs 0, lock_loss_cnt_o unchanged; reset_i mid-STAGGER -> all REQ-031 values.
REQ-038 Saturation: force 256 unlock events -> lock_loss_cnt_o holds 255.

Source files
------------

// File: rtl/adpll_gain_scheduler.sv
// rtl/adpll_gain_scheduler.sv - ADPLL loop-gain scheduler: staggered node enable, acquire/track gains, lock detect
//
// Purpose:
//   Brings up the four phase-detector nodes one at a time, spaced SETTLE_CYCLES
//   apart. It then runs the loop with acquisition gains until every enabled node
//   has been in-window for LOCK_COUNT consecutive reference edges. After that it
//   switches to tracking gains. It falls back to acquisition after UNLOCK_COUNT
//   consecutive out-of-window reference edges.
//
// Ports:
//   fpga_clk_i       sole clock, all state changes on its rising edge
//   reset_i          synchronous active-high reset
//   start_i          level; high runs the sequence, low forces IDLE
//   ref_i            reference clock, asynchronous to fpga_clk_i
//   error_i          four signed phase-error words, node n at [n*PDET_WIDTH +: PDET_WIDTH]
//   kp_acq_i/ki_acq_i  acquisition gains
//   kp_trk_i/ki_trk_i  tracking gains
//   node_enable_o    per-node enable, bit n = node n
//   kp_o/ki_o        registered gains broadcast to all nodes
//   locked_o         high only in TRACK
//   state_o          IDLE=0, STAGGER=1, ACQUIRE=2, TRACK=3
//   lock_loss_cnt_o  saturating count of TRACK->ACQUIRE transitions

module adpll_gain_scheduler #(
  parameter int PDET_WIDTH    = 5,
  parameter int KP_WIDTH      = 8,
  parameter int KI_WIDTH      = 10,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 64,
  parameter int UNLOCK_COUNT  = 4,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    ref_i,
  input  logic [4*PDET_WIDTH-1:0] error_i,
  input  logic [KP_WIDTH-1:0]     kp_acq_i,
  input  logic [KI_WIDTH-1:0]     ki_acq_i,
  input  logic [KP_WIDTH-1:0]     kp_trk_i,
  input  logic [KI_WIDTH-1:0]     ki_trk_i,
  output logic [3:0]              node_enable_o,
  output logic [KP_WIDTH-1:0]     kp_o,
  output logic [KI_WIDTH-1:0]     ki_o,
  output logic                    locked_o,
  output logic [1:0]              state_o,
  output logic [7:0]              lock_loss_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_ACQUIRE = 2'd2,
    ST_TRACK   = 2'd3
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [SW-1:0]         SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0]         GOOD_LAST   = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0]         BAD_LAST    = BW'(UNLOCK_COUNT - 1);
  localparam logic [PDET_WIDTH:0]   THRESH      = (PDET_WIDTH + 1)'(LOCK_THRESH);

  // Reference edge detection: two synchronizer flops, then one history flop.
  logic ref_meta;
  logic ref_sync;
  logic ref_prev;
  logic ref_tick;

  assign ref_tick = ref_sync & ~ref_prev;

  // Window check per node. The magnitude is taken one bit wider than the
  // error word so the most negative code maps to its true magnitude.
  logic [3:0] in_win;

  for (genvar n = 0; n < 4; n++) begin : g_node
    logic [PDET_WIDTH:0] err_ext;
    logic [PDET_WIDTH:0] err_mag;
    assign err_ext   = {error_i[n*PDET_WIDTH + PDET_WIDTH - 1], error_i[n*PDET_WIDTH +: PDET_WIDTH]};
    assign err_mag   = err_ext[PDET_WIDTH] ? ((PDET_WIDTH + 1)'(0) - err_ext) : err_ext;
    assign in_win[n] = (err_mag <= THRESH);
  end

  // Disabled nodes count as in-window so they cannot block or break lock.
  logic win_ok;
  assign win_ok = &(in_win | ~node_enable_o);

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [GW-1:0]   good_q, good_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic [3:0]      enable_d;
  logic [KP_WIDTH-1:0] kp_d;
  logic [KI_WIDTH-1:0] ki_d;
  logic            locked_d;
  logic [7:0]      loss_d;

  assign state_o = state_q;

  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ref_meta        <= 1'b0;
      ref_sync        <= 1'b0;
      ref_prev        <= 1'b0;
      state_q         <= ST_IDLE;
      settle_q        <= '0;
      good_q          <= '0;
      bad_q           <= '0;
      node_enable_o   <= '0;
      kp_o            <= '0;
      ki_o            <= '0;
      locked_o        <= 1'b0;
      lock_loss_cnt_o <= '0;
    end else begin
      ref_meta        <= ref_i;
      ref_sync        <= ref_meta;
      ref_prev        <= ref_sync;
      state_q         <= state_d;
      settle_q        <= settle_d;
      good_q          <= good_d;
      bad_q           <= bad_d;
      node_enable_o   <= enable_d;
      kp_o            <= kp_d;
      ki_o            <= ki_d;
      locked_o        <= locked_d;
      lock_loss_cnt_o <= loss_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    good_d   = good_q;
    bad_d    = bad_q;
    enable_d = node_enable_o;
    loss_d   = lock_loss_cnt_o;

    case (state_q)
      ST_IDLE: begin
        enable_d = 4'b0000;
        if (start_i) begin
          state_d  = ST_STAGGER;
          enable_d = 4'b0001;
          settle_d = '0;
        end
      end

      ST_STAGGER: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          if (node_enable_o == 4'b1111) begin
            state_d = ST_ACQUIRE;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            enable_d = {node_enable_o[2:0], 1'b1};
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_ACQUIRE: begin
        if (ref_tick) begin
          if (win_ok) begin
            if (good_q == GOOD_LAST) begin
              state_d = ST_TRACK;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + GW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
      end

      ST_TRACK: begin
        if (ref_tick) begin
          if (!win_ok) begin
            if (bad_q == BAD_LAST) begin
              state_d = ST_ACQUIRE;
              bad_d   = '0;
              good_d  = '0;
              if (lock_loss_cnt_o != 8'hFF) begin
                loss_d = lock_loss_cnt_o + 8'd1;
              end
            end else begin
              bad_d = bad_q + BW'(1);
            end
          end else begin
            bad_d = '0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping start wins over any same-cycle tick or settle wrap.
    if (!start_i) begin
      state_d  = ST_IDLE;
      enable_d = 4'b0000;
      settle_d = '0;
      good_d   = '0;
      bad_d    = '0;
      loss_d   = lock_loss_cnt_o;
    end

    // Gains and lock flag follow the next state so they move on the same
    // edge as state_o.
    kp_d     = '0;
    ki_d     = '0;
    locked_d = 1'b0;
    case (state_d)
      ST_STAGGER, ST_ACQUIRE: begin
        kp_d = kp_acq_i;
        ki_d = ki_acq_i;
      end
      ST_TRACK: begin
        kp_d     = kp_trk_i;
        ki_d     = ki_trk_i;
        locked_d = 1'b1;
      end
      default: begin
        kp_d = '0;
        ki_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// tb/tb_adpll_gain_scheduler.sv - self-checking bench for adpll_gain_scheduler

module tb_adpll_gain_scheduler;

  logic        fpga_clk_i;
  logic        reset_i;
  logic        start_i;
  logic        ref_i;
  logic [19:0] error_i;
  logic [7:0]  kp_acq_i, kp_trk_i;
  logic [9:0]  ki_acq_i, ki_trk_i;
  logic [3:0]  node_enable_o;
  logic [7:0]  kp_o;
  logic [9:0]  ki_o;
  logic        locked_o;
  logic [1:0]  state_o;
  logic [7:0]  lock_loss_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Event-level reference model
  int m_state = 0;
  int m_good  = 0;
  int m_bad   = 0;
  int m_loss  = 0;

  adpll_gain_scheduler #(
    .PDET_WIDTH(5), .KP_WIDTH(8), .KI_WIDTH(10), .LOCK_THRESH(2),
    .LOCK_COUNT(4), .UNLOCK_COUNT(2), .SETTLE_CYCLES(8)
  ) dut (
    .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .start_i(start_i), .ref_i(ref_i),
    .error_i(error_i), .kp_acq_i(kp_acq_i), .ki_acq_i(ki_acq_i),
    .kp_trk_i(kp_trk_i), .ki_trk_i(ki_trk_i), .node_enable_o(node_enable_o),
    .kp_o(kp_o), .ki_o(ki_o), .locked_o(locked_o), .state_o(state_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  initial fpga_clk_i = 1'b0;
  always #5 fpga_clk_i = ~fpga_clk_i;

  function automatic bit model_win(logic [19:0] e);
    logic signed [4:0] s;
    int v;
    for (int n = 0; n < 4; n++) begin
      s = e[n*5 +: 5];
      v = s;
      if (v < 0) v = -v;
      if (v > 2) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_kp(int st);
    if (st == 0) return 8'd0;
    if (st == 3) return kp_trk_i;
    return kp_acq_i;
  endfunction

  function automatic logic [9:0] exp_ki(int st);
    if (st == 0) return 10'd0;
    if (st == 3) return ki_trk_i;
    return ki_acq_i;
  endfunction

  // bad_node < 0 gives an all-good vector; otherwise that node gets |err| >= 3
  function automatic logic [19:0] gen_err(int bad_node);
    logic [19:0] e;
    int v;
    int mag;
    for (int n = 0; n < 4; n++) begin
      v = int'($urandom_range(0, 4)) - 2;
      if (n == bad_node) begin
        mag = int'($urandom_range(3, 16));
        if (mag == 16) v = -16;
        else v = ($urandom_range(0, 1) == 1) ? mag : -mag;
      end
      e[n*5 +: 5] = v[4:0];
    end
    return e;
  endfunction

  task automatic model_ref(logic [19:0] e);
    bit w;
    w = model_win(e);
    if (m_state == 2) begin
      if (w) begin
        m_good++;
        if (m_good == 4) begin m_state = 3; m_good = 0; m_bad = 0; end
      end else m_good = 0;
    end else if (m_state == 3) begin
      if (!w) begin
        m_bad++;
        if (m_bad == 2) begin
          m_state = 2; m_bad = 0; m_good = 0;
          if (m_loss < 255) m_loss++;
        end
      end else m_bad = 0;
    end
  endtask

  task automatic send_ref(logic [19:0] e);
    error_i = e;
    ref_i   = 1'b1;
    @(negedge fpga_clk_i);
    ref_i = 1'b0;
    repeat (5) @(negedge fpga_clk_i);
    model_ref(e);
  endtask

  task automatic go_acquire();
    start_i = 1'b0;
    @(negedge fpga_clk_i);
    start_i = 1'b1;
    repeat (33) @(negedge fpga_clk_i);
    m_state = 2; m_good = 0; m_bad = 0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b1;
    repeat (3) @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd0) $display("FAIL reset_state got %0d want 0", state_o); else n_pass++;
    n_checks++; if (node_enable_o !== 4'd0) $display("FAIL reset_en got %b want 0000", node_enable_o); else n_pass++;
    n_checks++; if (kp_o !== 8'd0 || ki_o !== 10'd0) $display("FAIL reset_gain got %0d/%0d want 0/0", kp_o, ki_o); else n_pass++;
    n_checks++; if (locked_o !== 1'b0) $display("FAIL reset_locked got %b want 0", locked_o); else n_pass++;
    n_checks++; if (lock_loss_cnt_o !== 8'd0) $display("FAIL reset_loss got %0d want 0", lock_loss_cnt_o); else n_pass++;
    start_i = 1'b0;
    reset_i = 1'b0;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd0) $display("FAIL idle_hold got %0d want 0", state_o); else n_pass++;
  endtask

  task automatic test_stagger();
    int idx;
    logic [3:0] en_exp;
    start_i = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge fpga_clk_i);
      idx = (c - 1) / 8;
      if (idx > 3) idx = 3;
      en_exp = 4'((1 << (idx + 1)) - 1);
      n_checks++; if (node_enable_o !== en_exp) $display("FAIL stagger_en c=%0d got %b want %b", c, node_enable_o, en_exp); else n_pass++;
      n_checks++; if (state_o !== ((c <= 32) ? 2'd1 : 2'd2)) $display("FAIL stagger_state c=%0d got %0d", c, state_o); else n_pass++;
      n_checks++; if (kp_o !== kp_acq_i || ki_o !== ki_acq_i) $display("FAIL stagger_gain c=%0d got %0d/%0d want %0d/%0d", c, kp_o, ki_o, kp_acq_i, ki_acq_i); else n_pass++;
    end
    m_state = 2; m_good = 0; m_bad = 0;
  endtask

  task automatic test_lock();
    logic [19:0] e;
    e = {5'b11110, 5'b00001, 5'b11110, 5'b00001};
    for (int i = 0; i < 3; i++) begin
      send_ref(e);
      n_checks++; if (state_o !== 2'd2) $display("FAIL lock_early i=%0d got %0d want 2", i, state_o); else n_pass++;
    end
    error_i = e;
    ref_i = 1'b1;
    @(negedge fpga_clk_i);
    ref_i = 1'b0;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd2) $display("FAIL lock_latency got %0d want 2", state_o); else n_pass++;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd3 || locked_o !== 1'b1) $display("FAIL lock_state got %0d/%b want 3/1", state_o, locked_o); else n_pass++;
    n_checks++; if (kp_o !== kp_trk_i || ki_o !== ki_trk_i) $display("FAIL lock_gain got %0d/%0d want %0d/%0d", kp_o, ki_o, kp_trk_i, ki_trk_i); else n_pass++;
    repeat (3) @(negedge fpga_clk_i);
    model_ref(e);
  endtask

  task automatic test_window_reset();
    logic [19:0] e;
    go_acquire();
    for (int i = 0; i < 8; i++) begin
      e = gen_err(-1);
      if (i == 3) e[19:15] = 5'd3;
      send_ref(e);
      n_checks++; if (state_o !== ((i == 7) ? 2'd3 : 2'd2)) $display("FAIL window_reset edge=%0d got %0d", i + 1, state_o); else n_pass++;
    end
  endtask

  task automatic test_unlock();
    logic [19:0] e;
    e = gen_err(-1);
    e[4:0] = 5'b10000;
    send_ref(e);
    n_checks++; if (state_o !== 2'd3) $display("FAIL unlock_first got %0d want 3", state_o); else n_pass++;
    send_ref(e);
    n_checks++; if (state_o !== 2'd2 || locked_o !== 1'b0) $display("FAIL unlock_state got %0d/%b want 2/0", state_o, locked_o); else n_pass++;
    n_checks++; if (lock_loss_cnt_o !== 8'd1) $display("FAIL unlock_cnt got %0d want 1", lock_loss_cnt_o); else n_pass++;
    n_checks++; if (kp_o !== kp_acq_i || ki_o !== ki_acq_i) $display("FAIL unlock_gain got %0d/%0d", kp_o, ki_o); else n_pass++;
    for (int i = 0; i < 4; i++) send_ref(gen_err(-1));
    for (int i = 0; i < 4; i++) begin
      send_ref(gen_err((i % 2 == 0) ? int'($urandom_range(0, 3)) : -1));
      n_checks++; if (state_o !== 2'd3) $display("FAIL unlock_alt i=%0d got %0d want 3", i, state_o); else n_pass++;
    end
  endtask

  task automatic test_gain_change();
    kp_trk_i = 8'($urandom);
    ki_trk_i = 10'($urandom);
    kp_acq_i = 8'($urandom);
    @(negedge fpga_clk_i);
    n_checks++; if (kp_o !== kp_trk_i || ki_o !== ki_trk_i) $display("FAIL gain_change got %0d/%0d want %0d/%0d", kp_o, ki_o, kp_trk_i, ki_trk_i); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      send_ref(gen_err(($urandom_range(0, 9) < 7) ? -1 : int'($urandom_range(0, 3))));
      n_checks++; if (state_o !== 2'(m_state)) $display("FAIL rand_state i=%0d got %0d want %0d", i, state_o, m_state); else n_pass++;
      n_checks++; if (locked_o !== (m_state == 3)) $display("FAIL rand_locked i=%0d got %b", i, locked_o); else n_pass++;
      n_checks++; if (kp_o !== exp_kp(m_state) || ki_o !== exp_ki(m_state)) $display("FAIL rand_gain i=%0d got %0d/%0d", i, kp_o, ki_o); else n_pass++;
      n_checks++; if (lock_loss_cnt_o !== 8'(m_loss)) $display("FAIL rand_loss i=%0d got %0d want %0d", i, lock_loss_cnt_o, m_loss); else n_pass++;
      n_checks++; if (node_enable_o !== 4'hF) $display("FAIL rand_en i=%0d got %b want 1111", i, node_enable_o); else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [19:0] e;
    logic [7:0]  loss_saved;
    for (int i = 0; i < 6 && m_state != 3; i++) send_ref(gen_err(-1));
    send_ref(gen_err(-1));
    e = gen_err(1);
    send_ref(e);
    loss_saved = 8'(m_loss);
    error_i = e;
    ref_i = 1'b1;
    @(negedge fpga_clk_i);
    ref_i = 1'b0;
    @(negedge fpga_clk_i);
    start_i = 1'b0;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd0 || locked_o !== 1'b0) $display("FAIL abort_state got %0d/%b want 0/0", state_o, locked_o); else n_pass++;
    n_checks++; if (node_enable_o !== 4'd0 || kp_o !== 8'd0 || ki_o !== 10'd0) $display("FAIL abort_outs got %b/%0d/%0d want 0", node_enable_o, kp_o, ki_o); else n_pass++;
    n_checks++; if (lock_loss_cnt_o !== loss_saved) $display("FAIL abort_loss got %0d want %0d", lock_loss_cnt_o, loss_saved); else n_pass++;
    m_state = 0; m_good = 0; m_bad = 0;
    start_i = 1'b1;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd1 || node_enable_o !== 4'b0001) $display("FAIL restart got %0d/%b want 1/0001", state_o, node_enable_o); else n_pass++;
    repeat (9) @(negedge fpga_clk_i);
    reset_i = 1'b1;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd0 || node_enable_o !== 4'd0 || locked_o !== 1'b0) $display("FAIL midreset_state got %0d/%b/%b", state_o, node_enable_o, locked_o); else n_pass++;
    n_checks++; if (kp_o !== 8'd0 || ki_o !== 10'd0 || lock_loss_cnt_o !== 8'd0) $display("FAIL midreset_vals got %0d/%0d/%0d want 0", kp_o, ki_o, lock_loss_cnt_o); else n_pass++;
    m_loss = 0;
    reset_i = 1'b0;
    @(negedge fpga_clk_i);
    n_checks++; if (state_o !== 2'd1 || node_enable_o !== 4'b0001) $display("FAIL postreset got %0d/%b want 1/0001", state_o, node_enable_o); else n_pass++;
  endtask

  task automatic test_saturation();
    go_acquire();
    for (int i = 0; i < 256; i++) begin
      for (int g = 0; g < 4; g++) send_ref(gen_err(-1));
      send_ref(gen_err(int'($urandom_range(0, 3))));
      send_ref(gen_err(int'($urandom_range(0, 3))));
      if (i == 9) begin
        n_checks++; if (lock_loss_cnt_o !== 8'd10) $display("FAIL sat_mid got %0d want 10", lock_loss_cnt_o); else n_pass++;
      end
      if (i == 254) begin
        n_checks++; if (lock_loss_cnt_o !== 8'd255) $display("FAIL sat_255 got %0d want 255", lock_loss_cnt_o); else n_pass++;
      end
    end
    n_checks++; if (lock_loss_cnt_o !== 8'd255 || lock_loss_cnt_o !== 8'(m_loss)) $display("FAIL sat_hold got %0d want 255", lock_loss_cnt_o); else n_pass++;
    n_checks++; if (state_o !== 2'd2) $display("FAIL sat_state got %0d want 2", state_o); else n_pass++;
  endtask

  initial begin
    reset_i  = 1'b1;
    start_i  = 1'b0;
    ref_i    = 1'b0;
    error_i  = '0;
    kp_acq_i = 8'($urandom);
    ki_acq_i = 10'($urandom);
    kp_trk_i = 8'($urandom);
    ki_trk_i = 10'($urandom);
    test_reset();
    test_stagger();
    test_lock();
    test_window_reset();
    test_unlock();
    test_gain_change();
    test_random();
    test_abort();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
